data_memory_responder: RTL and testbench
========================================

# data_memory_responder

Data-memory responder for the riscv_small core's memory-access (MA) stage. It serves the core's data-side requests: byte, halfword and word loads and stores. Wait states are programmable, and completion is signalled with a one-cycle `data_ready` pulse. It sits between the core's MA-stage request outputs and an internal word-organised storage array, and is used as the data memory in simulation and FPGA builds.

## Interface

Parameters:
- `DEPTH`, 1024 — storage size in 32-bit words; power of two.
- `LATENCY`, 0 — wait-state cycles inserted before each response (0..15).
- `INIT_FILE`, "" — hex image loaded into the array at elaboration when non-empty.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1 — clock.
- `rst_n` in 1 — asynchronous reset, active low.
- `data_addr` in 32 — byte address (the core's ALU result in MA).
- `data_rd_en` in 1 — load request; held until `data_ready`.
- `data_wr_en` in 1 — store request; held until `data_ready`.
- `data_wr` in 32 (`dataBus_u`) — store data, right-justified.
- `data_rd_wr_ctrl` in 2 — access size: 2'b00 byte, 2'b01 half, 2'b10 word; 2'b11 is illegal.
- `data_rd` out 32 (`dataBus_u`) — load data, right-justified and zero-extended; the core performs sign extension.
- `data_ready` out 1 — one-cycle completion pulse.
- `misaligned` out 1 — one-cycle error pulse, coincident with `data_ready`.

## Operation

- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - When `data_rd_en | data_wr_en` is high, latch address, store data, size and op.
  - Load the wait counter with `LATENCY`.
  - Go to WAIT if `LATENCY > 0`, else go straight to RESP.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter equals 1, go to RESP.
- **Access execution.** The access is performed on the edge entering RESP, using the latched values:
  - Word index = `addr[log2(DEPTH)+1:2]`; upper address bits are ignored, so addresses wrap modulo `4*DEPTH`.
  - Store: byte enables are derived from size and `addr[1:0]`. Store data is replicated to the addressed lane(s); only enabled bytes change.
  - Load: the addressed byte or half is shifted down and zero-extended, then registered into `data_rd`.
- **RESP**
  - `data_ready` = 1 for exactly this cycle, then return to IDLE.
  - The core's still-asserted request is ignored during RESP.
  - A new request is sampled no earlier than the following IDLE cycle.
- **Error cases.** The following raise `misaligned` in RESP:
  - half with `addr[0]` = 1;
  - word with `addr[1:0]` ≠ 0;
  - size 2'b11;
  - `rd_en` and `wr_en` both high.
  
  On an error the store is suppressed, `data_rd` is set to 0, and `data_ready` still pulses so the pipeline never hangs.
- `data_rd` holds its value until the next load response; stores do not change it.
- Array contents are not reset.

## Timing

- A request first visible in IDLE at cycle n produces `data_ready` in cycle n+`LATENCY`+1.
- Back-to-back requests: the next response arrives no earlier than n+`LATENCY`+3.
- Write data is readable by a load accepted in the cycle after RESP (no bypass is needed).
- Reset values: state IDLE, counter 0, `data_ready` 0, `misaligned` 0, `data_rd` 0.
- Reset asserted mid-access:
  - return to IDLE immediately;
  - a pending store is dropped (the array is unchanged);
  - no `data_ready` is produced.
- Request deasserted during WAIT: protocol violation. The latched access still completes and `data_ready` still pulses.

## Structure

- Shared package additions:
  - `memSize_e` (MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10);
  - `memRespState_e` (IDLE/WAIT/RESP).
- Reused from the existing package: `dataBus_u`.
- One sub-module, `mem_lane_align`, purely combinational:
  - inputs: size, `addr[1:0]`, store word, read word;
  - outputs: 4-bit byte-enable, replicated store word, right-justified load word, misalign flag.
- The top contains the FSM, counter, latches and the array (inferred RAM, byte-enabled write).

## Test plan

- **Word store/load, `LATENCY`=0.** Store 0xDEADBEEF to 0x10, then load 0x10 → `data_ready` one cycle after each request; `data_rd` = 0xDEADBEEF.
- **Byte lanes.** After the word above, store byte 0x55 to 0x13, then word-load 0x10 → 0x55ADBEEF. Byte-load 0x12 → 0x000000AD. Half-load 0x10 → 0x0000BEEF.
- **Wait states, `LATENCY`=3.** Load request held → `data_ready` exactly 4 cycles after the request first appears, high for 1 cycle. Back-to-back loads → pulses 6 cycles apart.
- **Misalignment.** Half store to 0x11 with data 0x1234 → `misaligned` and `data_ready` pulse together. A following word load of 0x10 returns the unchanged word. Word load of 0x02 → `data_rd` = 0, `misaligned` = 1.
- **Address wrap, `DEPTH`=1024.** Store 0xA5A5A5A5 to 0x1000, then load 0x0000 → 0xA5A5A5A5.
- **Reset mid-access, `LATENCY`=5.** Assert `rst_n`=0 two cycles after a store request → no `data_ready`; after reset, a load of that address returns its old contents; all outputs read 0 during reset.

Source files
------------

// File: rtl/data_memory_responder_pkg.sv
// Shared types for the data-side memory responder of the riscv_small core.
// Bus union, access-size encoding and responder FSM states.
package data_memory_responder_pkg;

  typedef union packed {
    logic [31:0]     word;
    logic [3:0][7:0] lane;
  } dataBus_u;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } memSize_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } memRespState_e;

endpackage

// File: rtl/data_memory_responder_lane_align.sv
// Combinational byte-lane steering: store enables/replication, load alignment and
// misalignment detection for byte, half and word accesses.
module mem_lane_align
  import data_memory_responder_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  input  dataBus_u   wr_word,
  input  dataBus_u   rd_word,
  output logic [3:0] byte_en,
  output dataBus_u   wr_lanes,
  output dataBus_u   rd_aligned,
  output logic       misalign
);

  always_comb begin
    byte_en    = 4'b0000;
    wr_lanes   = wr_word;
    rd_aligned = '0;
    misalign   = 1'b0;
    case (size)
      MEM_BYTE: begin
        byte_en         = 4'b0001 << addr_lo;
        wr_lanes.word   = {4{wr_word.lane[0]}};
        rd_aligned.word = {24'h0, rd_word.lane[addr_lo]};
      end
      MEM_HALF: begin
        misalign        = addr_lo[0];
        byte_en         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wr_lanes.word   = {2{wr_word.word[15:0]}};
        rd_aligned.word = {16'h0, addr_lo[1] ? rd_word.word[31:16] : rd_word.word[15:0]};
      end
      MEM_WORD: begin
        misalign   = |addr_lo;
        byte_en    = 4'b1111;
        rd_aligned = rd_word;
      end
      default: misalign = 1'b1;
    endcase
    // A misaligned access must never touch the array.
    if (misalign) begin
      byte_en = 4'b0000;
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// Data memory for the MA stage: byte/half/word loads and stores with programmable
// wait states, a one-cycle data_ready pulse and a coincident misaligned pulse.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 0,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_addr,
  input  logic        data_rd_en,
  input  logic        data_wr_en,
  input  dataBus_u    data_wr,
  input  logic [1:0]  data_rd_wr_ctrl,
  output dataBus_u    data_rd,
  output logic        data_ready,
  output logic        misaligned
);

  localparam int unsigned AW = $clog2(DEPTH);

  memRespState_e state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW+1:0] addr_q;
  dataBus_u      wdata_q;
  logic [1:0]    size_q;
  logic          rd_q, wr_q;

  logic [31:0]   mem [DEPTH];

  logic          live, enter_resp, acc_rd, acc_wr, acc_err, lane_mis;
  logic [AW+1:0] acc_addr;
  logic [AW-1:0] acc_idx;
  logic [1:0]    acc_size;
  dataBus_u      acc_wdata, rd_word, wr_lanes, rd_aligned;
  logic [3:0]    byte_en;

  logic unused_addr_hi;
  assign unused_addr_hi = ^data_addr[31:AW+2];

  // With zero latency the access executes on the same edge that samples the request.
  assign live      = (state_q == IDLE);
  assign acc_addr  = live ? data_addr[AW+1:0] : addr_q;
  assign acc_wdata = live ? data_wr : wdata_q;
  assign acc_size  = live ? data_rd_wr_ctrl : size_q;
  assign acc_rd    = live ? data_rd_en : rd_q;
  assign acc_wr    = live ? data_wr_en : wr_q;
  assign acc_idx   = acc_addr[AW+1:2];
  assign rd_word   = mem[acc_idx];
  assign acc_err   = lane_mis | (acc_rd & acc_wr);

  mem_lane_align u_lane_align (
    .size       (acc_size),
    .addr_lo    (acc_addr[1:0]),
    .wr_word    (acc_wdata),
    .rd_word    (rd_word),
    .byte_en    (byte_en),
    .wr_lanes   (wr_lanes),
    .rd_aligned (rd_aligned),
    .misalign   (lane_mis)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (data_rd_en | data_wr_en) begin
          cnt_d      = 4'(LATENCY);
          state_d    = (LATENCY > 0) ? WAIT : RESP;
          enter_resp = (LATENCY == 0);
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= 2'b00;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      data_ready <= 1'b0;
      misaligned <= 1'b0;
      data_rd    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_ready <= enter_resp;
      misaligned <= enter_resp & acc_err;
      if (live && (data_rd_en || data_wr_en)) begin
        addr_q  <= data_addr[AW+1:0];
        wdata_q <= data_wr;
        size_q  <= data_rd_wr_ctrl;
        rd_q    <= data_rd_en;
        wr_q    <= data_wr_en;
      end
      if (enter_resp && (acc_rd || acc_err)) begin
        data_rd <= acc_err ? '0 : rd_aligned;
      end
    end
  end

  // Storage is not reset; rst_n gates the write so a request held through reset is dropped.
  always_ff @(posedge clk) begin
    if (enter_resp && acc_wr && !acc_err && rst_n) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[acc_idx][8*b +: 8] <= wr_lanes.lane[b];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: three instances (LATENCY 0, 3, 5),
// directed requests push expected responses, a negedge monitor pops and compares.
module tb_data_memory_responder;
  import data_memory_responder_pkg::*;

  localparam int N = 3;

  typedef struct {
    logic [31:0] rd;
    bit          mis;
    bit          chk_rd;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n   [N];
  logic [31:0] addr    [N];
  logic [31:0] wdata   [N];
  logic [1:0]  size    [N];
  logic        rd_en   [N];
  logic        wr_en   [N];
  logic [31:0] rdata   [N];
  logic        ready   [N];
  logic        mis     [N];

  exp_t exp_q   [N][$];
  int   ready_t [N][$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    data_memory_responder #(
      .DEPTH     (1024),
      .LATENCY   ((g == 0) ? 0 : (g == 1) ? 3 : 5),
      .INIT_FILE ("")
    ) u_dut (
      .clk             (clk),
      .rst_n           (rst_n[g]),
      .data_addr       (addr[g]),
      .data_rd_en      (rd_en[g]),
      .data_wr_en      (wr_en[g]),
      .data_wr         (wdata[g]),
      .data_rd_wr_ctrl (size[g]),
      .data_rd         (rdata[g]),
      .data_ready      (ready[g]),
      .misaligned      (mis[g])
    );
  end

  function automatic int lat(input int d);
    return (d == 0) ? 0 : (d == 1) ? 3 : 5;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Monitor: every data_ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < N; i++) begin
      if (ready[i] === 1'b1) begin
        ready_t[i].push_back(cyc_cnt);
        if (exp_q[i].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_ready dut%0d: got ready 1, expected 0", i);
        end else begin
          e = exp_q[i].pop_front();
          check({e.name, "_mis"}, {31'b0, mis[i]}, {31'b0, e.mis});
          if (e.chk_rd) check({e.name, "_rd"}, rdata[i], e.rd);
        end
      end else if (mis[i] === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL lone_misaligned dut%0d: got misaligned 1 without ready", i);
      end
    end
  end

  task automatic req(input int d, input bit rd, input bit wr, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] erd,
                     input bit emis, input bit chk, input string nm);
    exp_t e;
    int   cyc = 0;
    e.rd = erd;
    e.mis = emis;
    e.chk_rd = chk;
    e.name = nm;
    exp_q[d].push_back(e);
    addr[d]  = a;
    wdata[d] = wd;
    size[d]  = sz;
    rd_en[d] = rd;
    wr_en[d] = wr;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (ready[d] !== 1'b1 && cyc < 40);
    rd_en[d] = 1'b0;
    wr_en[d] = 1'b0;
    check({nm, "_latency"}, 32'(cyc), 32'(lat(d) + 1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t0, t1;
    for (int i = 0; i < N; i++) begin
      rst_n[i] = 1'b0;
      addr[i]  = '0;
      wdata[i] = '0;
      size[i]  = 2'b00;
      rd_en[i] = 1'b0;
      wr_en[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset_rd%0d", i), rdata[i], 32'h0);
      check($sformatf("reset_ready%0d", i), {31'b0, ready[i]}, 32'h0);
      check($sformatf("reset_mis%0d", i), {31'b0, mis[i]}, 32'h0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
    @(posedge clk);
    #1;

    // LATENCY 0: word, byte-lane and half accesses
    req(0, 0, 1, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0,        0, 0, "st_word");
    req(0, 1, 0, 2'b10, 32'h10, 32'h0,        32'hDEADBEEF, 0, 1, "ld_word");
    req(0, 0, 1, 2'b00, 32'h13, 32'h00000055, 32'h0,        0, 0, "st_byte3");
    req(0, 1, 0, 2'b10, 32'h10, 32'h0,        32'h55ADBEEF, 0, 1, "ld_word_b3");
    req(0, 1, 0, 2'b00, 32'h12, 32'h0,        32'h000000AD, 0, 1, "ld_byte2");
    req(0, 1, 0, 2'b01, 32'h10, 32'h0,        32'h0000BEEF, 0, 1, "ld_half0");
    req(0, 1, 0, 2'b01, 32'h12, 32'h0,        32'h000055AD, 0, 1, "ld_half2");
    // Error cases: store suppressed, data_rd cleared, ready still pulses
    req(0, 0, 1, 2'b01, 32'h11, 32'h00001234, 32'h0,        1, 0, "st_half_mis");
    req(0, 1, 0, 2'b10, 32'h10, 32'h0,        32'h55ADBEEF, 0, 1, "ld_after_mis");
    req(0, 1, 0, 2'b10, 32'h02, 32'h0,        32'h0,        1, 1, "ld_word_mis");
    req(0, 1, 0, 2'b10, 32'h10, 32'h0,        32'h55ADBEEF, 0, 1, "ld_reload");
    req(0, 1, 0, 2'b11, 32'h10, 32'h0,        32'h0,        1, 1, "ld_size11");
    req(0, 1, 1, 2'b10, 32'h10, 32'h12345678, 32'h0,        1, 1, "rd_wr_both");
    req(0, 1, 0, 2'b10, 32'h10, 32'h0,        32'h55ADBEEF, 0, 1, "ld_after_both");
    // Address wrap modulo 4*DEPTH, and data_rd held across a store
    req(0, 0, 1, 2'b10, 32'h1000, 32'hA5A5A5A5, 32'h0,        0, 0, "st_wrap");
    req(0, 1, 0, 2'b10, 32'h0000, 32'h0,        32'hA5A5A5A5, 0, 1, "ld_wrap");
    req(0, 0, 1, 2'b00, 32'h0001, 32'h00000077, 32'hA5A5A5A5, 0, 1, "st_keeps_rd");
    req(0, 1, 0, 2'b10, 32'h0000, 32'h0,        32'hA5A577A5, 0, 1, "ld_byte1");

    // LATENCY 3: wait states and pulse spacing with a one-cycle bubble between loads
    req(1, 0, 1, 2'b10, 32'h40, 32'hCAFEF00D, 32'h0,        0, 0, "l3_st");
    req(1, 1, 0, 2'b10, 32'h40, 32'h0,        32'hCAFEF00D, 0, 1, "l3_ld_a");
    @(posedge clk);
    #1;
    req(1, 1, 0, 2'b01, 32'h42, 32'h0,        32'h0000CAFE, 0, 1, "l3_ld_b");
    if (ready_t[1].size() >= 2) begin
      t0 = ready_t[1][ready_t[1].size() - 2];
      t1 = ready_t[1][ready_t[1].size() - 1];
      check("l3_spacing", 32'(t1 - t0), 32'd6);
    end else begin
      check("l3_pulse_count", 32'(ready_t[1].size()), 32'd2);
    end

    // LATENCY 5: reset two cycles into a store drops it and produces no response
    req(2, 0, 1, 2'b10, 32'h20, 32'h11223344, 32'h0,        0, 0, "l5_st");
    req(2, 1, 0, 2'b10, 32'h20, 32'h0,        32'h11223344, 0, 1, "l5_ld");
    addr[2]  = 32'h20;
    wdata[2] = 32'hFFFFFFFF;
    size[2]  = 2'b10;
    wr_en[2] = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n[2] = 1'b0;
    wr_en[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("midrst_rd", rdata[2], 32'h0);
      check("midrst_ready", {31'b0, ready[2]}, 32'h0);
      check("midrst_mis", {31'b0, mis[2]}, 32'h0);
    end
    @(posedge clk);
    #1;
    rst_n[2] = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    req(2, 1, 0, 2'b10, 32'h20, 32'h0,        32'h11223344, 0, 1, "l5_ld_after_rst");

    repeat (10) @(posedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("outstanding_dut%0d", i), 32'(exp_q[i].size()), 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
